reaction_timer_spi: RTL and testbench

Combined reaction-timing and SPI-readback block for the TinyTapeout reaction-counter tile. The timer section measures the delay between the LED turning on and a button press, in prescaled ticks. It saturates at 255 and holds the result on time_out. The SPI section is an independent, free-running SPI master (mode 0, MSB first) that repeatedly reads one byte from an external device and presents it on data_out. The top level drives data_out onto uio_out.

---
 rtl/reaction_timer_spi_if.sv | 16 +
 rtl/reaction_timer_spi.sv | 209 ++++++++++++++++++++
 tb/tb_reaction_timer_spi.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_spi_if.sv
// ----------------------------------------------------------------------------
// reaction_timer_spi_if : SPI bus between the readback master and its slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface reaction_timer_spi_if;
  logic sclk;
  logic cs;
  logic miso;

  modport master (output sclk, output cs, input miso);
  modport slave  (input sclk, input cs, output miso);
endinterface

`default_nettype wire

// File: rtl/reaction_timer_spi.sv
// ----------------------------------------------------------------------------
// reaction_timer_spi : reaction timer plus free-running one-byte SPI reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reaction_timer_spi #(
  parameter int PRESCALE = 1000,
  parameter int SPI_DIV  = 4,
  parameter int SPI_GAP  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             button_i,
  input  wire logic             led_on_i,
  output logic [7:0]            time_out_o,
  output logic                  done_o,
  output logic                  false_start_o,
  output logic [7:0]            data_out_o,
  reaction_timer_spi_if.master  spi
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int GW = (SPI_GAP > 1) ? $clog2(SPI_GAP) : 1;

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_COUNT = 2'd1, T_DONE = 2'd2} t_state_e;
  typedef enum logic       {S_GAP = 1'b0, S_XFER = 1'b1} s_state_e;

  logic btn_s1_q, btn_s2_q, btn_dly_q;
  logic led_s1_q, led_s2_q, led_dly_q;
  logic w_btn_rise, w_led_rise, w_led_fall;

  t_state_e        t_state_q, t_state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      ticks_q, ticks_d;
  logic [7:0]      time_q, time_d;
  logic            done_q, done_d;
  logic            fs_q, fs_d;

  s_state_e        s_state_q, s_state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      btn_dly_q <= 1'b0;
      led_s1_q  <= 1'b0;
      led_s2_q  <= 1'b0;
      led_dly_q <= 1'b0;
    end else begin
      btn_s1_q  <= button_i;
      btn_s2_q  <= btn_s1_q;
      btn_dly_q <= btn_s2_q;
      led_s1_q  <= led_on_i;
      led_s2_q  <= led_s1_q;
      led_dly_q <= led_s2_q;
    end
  end

  assign w_btn_rise = btn_s2_q & ~btn_dly_q;
  assign w_led_rise = led_s2_q & ~led_dly_q;
  assign w_led_fall = ~led_s2_q & led_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state_q <= T_IDLE;
      presc_q   <= '0;
      ticks_q   <= '0;
      time_q    <= '0;
      done_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      presc_q   <= presc_d;
      ticks_q   <= ticks_d;
      time_q    <= time_d;
      done_q    <= done_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    t_state_d = t_state_q;
    presc_d   = presc_q;
    ticks_d   = ticks_q;
    time_d    = time_q;
    done_d    = 1'b0;
    fs_d      = fs_q;
    case (t_state_q)
      T_IDLE: begin
        if (w_led_rise) begin
          t_state_d = T_COUNT;
          presc_d   = '0;
          ticks_d   = '0;
          fs_d      = 1'b0;
        end else if (w_btn_rise && !led_s2_q) begin
          fs_d = 1'b1;
        end
      end
      T_COUNT: begin
        if (presc_q == PW'(PRESCALE - 1)) begin
          presc_d = '0;
          if (ticks_q != 8'hFF) ticks_d = ticks_q + 8'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // A press in the same cycle as the LED dropping still counts as a result
        if (w_btn_rise) begin
          t_state_d = T_DONE;
          time_d    = ticks_q;
          done_d    = 1'b1;
        end else if (w_led_fall) begin
          t_state_d = T_IDLE;
        end
      end
      T_DONE: begin
        if (!led_s2_q && !btn_s2_q) t_state_d = T_IDLE;
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state_q <= S_GAP;
      gap_q     <= '0;
      div_q     <= '0;
      bit_q     <= 3'd7;
      shreg_q   <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      s_state_q <= s_state_d;
      gap_q     <= gap_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
    end
  end

  always_comb begin
    s_state_d = s_state_q;
    gap_d     = gap_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    case (s_state_q)
      S_GAP: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        if (gap_q == GW'(SPI_GAP - 1)) begin
          s_state_d = S_XFER;
          gap_d     = '0;
          div_d     = '0;
          bit_d     = 3'd7;
          cs_d      = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_XFER: begin
        if (div_q == DW'(SPI_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shreg_d[bit_q] = spi.miso;
          end else if (bit_q == 3'd0) begin
            // Eighth falling edge: publish the byte and release the slave together
            s_state_d = S_GAP;
            gap_d     = '0;
            sclk_d    = 1'b0;
            cs_d      = 1'b1;
            data_d    = shreg_q;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: s_state_d = S_GAP;
    endcase
  end

  assign time_out_o    = time_q;
  assign done_o        = done_q;
  assign false_start_o = fs_q;
  assign data_out_o    = data_q;
  assign spi.sclk      = sclk_q;
  assign spi.cs        = cs_q;

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer_spi.sv
// ----------------------------------------------------------------------------
// tb_reaction_timer_spi : randomized bench with a behavioural timer/SPI model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reaction_timer_spi;

  localparam int PRESCALE = 4;
  localparam int SPI_DIV  = 2;
  localparam int SPI_GAP  = 4;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       led_on;
  logic [7:0] time_out;
  logic       done;
  logic       false_start;
  logic [7:0] data_out;

  reaction_timer_spi_if spi_if ();

  reaction_timer_spi #(
    .PRESCALE (PRESCALE),
    .SPI_DIV  (SPI_DIV),
    .SPI_GAP  (SPI_GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_i      (button),
    .led_on_i      (led_on),
    .time_out_o    (time_out),
    .done_o        (done),
    .false_start_o (false_start),
    .data_out_o    (data_out),
    .spi           (spi_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         total;
  int         bad;
  int         done_seen;
  logic [7:0] exp_time;
  logic [7:0] exp_data;

  // Press and LED share the synchroniser delay, so a press seen d cycles after the
  // LED finds d-1 prescaler steps completed; the result saturates at 255.
  function automatic logic [7:0] model_ticks(input int d);
    int t;
    t = (d - 1) / PRESCALE;
    if (t > 255) t = 255;
    return 8'(t);
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    button = 1'b0;
    led_on = 1'b0;
    spi_if.miso = 1'b0;
    exp_time = 8'd0;
    exp_data = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if (time_out !== 8'd0 || done !== 1'b0 || false_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_timer time_out=%0d done=%b fs=%b required 0/0/0", time_out, done, false_start);
    end
    total++;
    if (data_out !== 8'd0 || spi_if.cs !== 1'b1 || spi_if.sclk !== 1'b0) begin
      bad++;
      $display("FAIL reset_spi data=%h cs=%b sclk=%b required 00/1/0", data_out, spi_if.cs, spi_if.sclk);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_normal(input int delay);
    logic [7:0] want;
    want = model_ticks(delay);
    done_seen = 0;
    led_on = 1'b1;
    cyc(delay);
    button = 1'b1;
    cyc(8);
    exp_time = want;
    total++;
    if (done_seen != 1) begin
      bad++;
      $display("FAIL normal_done_pulses delay=%0d got=%0d required=1", delay, done_seen);
    end
    total++;
    if (time_out !== want) begin
      bad++;
      $display("FAIL normal_time delay=%0d got=%0d required=%0d", delay, time_out, want);
    end
    button = 1'b0;
    led_on = 1'b0;
    cyc(10);
    total++;
    if (time_out !== exp_time || done_seen != 1) begin
      bad++;
      $display("FAIL normal_hold got=%0d pulses=%0d required=%0d pulses=1", time_out, done_seen, exp_time);
    end
  endtask

  task automatic test_saturation;
    done_seen = 0;
    led_on = 1'b1;
    cyc(2000);
    button = 1'b1;
    cyc(8);
    exp_time = 8'd255;
    total++;
    if (time_out !== 8'd255 || done_seen != 1) begin
      bad++;
      $display("FAIL saturation got=%0d pulses=%0d required=255 pulses=1", time_out, done_seen);
    end
    button = 1'b0;
    led_on = 1'b0;
    cyc(10);
  endtask

  task automatic test_false_start;
    done_seen = 0;
    button = 1'b1;
    cyc(2 + $urandom_range(0, 3));
    button = 1'b0;
    cyc(6);
    total++;
    if (false_start !== 1'b1 || time_out !== exp_time || done_seen != 0) begin
      bad++;
      $display("FAIL false_start_set fs=%b time=%0d pulses=%0d required fs=1 time=%0d pulses=0",
               false_start, time_out, done_seen, exp_time);
    end
    led_on = 1'b1;
    cyc(5);
    total++;
    if (false_start !== 1'b0) begin
      bad++;
      $display("FAIL false_start_clear fs=%b required=0", false_start);
    end
    led_on = 1'b0;
    cyc(8);
  endtask

  task automatic test_abort(input int hold);
    done_seen = 0;
    led_on = 1'b1;
    cyc(hold);
    led_on = 1'b0;
    cyc(10);
    total++;
    if (done_seen != 0 || time_out !== exp_time) begin
      bad++;
      $display("FAIL abort pulses=%0d time=%0d required pulses=0 time=%0d", done_seen, time_out, exp_time);
    end
  endtask

  task automatic test_spi(input logic [7:0] b);
    int         guard;
    int         low_cyc;
    int         rises;
    int         idx;
    logic       prev_sclk;
    logic       held;
    guard = 0;
    while (spi_if.cs !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    while (spi_if.cs !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL spi_start cs never fell within 200 cycles");
      return;
    end
    idx = 7;
    spi_if.miso = b[7];
    low_cyc = 0;
    rises = 0;
    held = 1'b1;
    prev_sclk = spi_if.sclk;
    while (spi_if.cs === 1'b0 && low_cyc < 200) begin
      low_cyc++;
      if (data_out !== exp_data) held = 1'b0;
      @(negedge clk);
      if (!prev_sclk && spi_if.sclk) rises++;
      if (prev_sclk && !spi_if.sclk && idx > 0) begin
        idx--;
        spi_if.miso = b[idx];
      end
      prev_sclk = spi_if.sclk;
    end
    total++;
    if (low_cyc != 16 * SPI_DIV || rises != 8) begin
      bad++;
      $display("FAIL spi_framing cs_low=%0d rises=%0d required %0d/8", low_cyc, rises, 16 * SPI_DIV);
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL spi_data_held data changed mid-transaction, required %h", exp_data);
    end
    exp_data = b;
    total++;
    if (data_out !== exp_data) begin
      bad++;
      $display("FAIL spi_data got=%h required=%h", data_out, exp_data);
    end
  endtask

  task automatic test_reset_mid;
    int guard;
    guard = 0;
    while (spi_if.cs !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
    cyc(7);
    #2;
    rst_n = 1'b0;
    #1;
    exp_time = 8'd0;
    exp_data = 8'd0;
    total++;
    if (spi_if.cs !== 1'b1 || spi_if.sclk !== 1'b0 || data_out !== exp_data) begin
      bad++;
      $display("FAIL reset_mid_spi cs=%b sclk=%b data=%h required 1/0/00", spi_if.cs, spi_if.sclk, data_out);
    end
    total++;
    if (time_out !== exp_time || done !== 1'b0 || false_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_timer time=%0d done=%b fs=%b required 0/0/0", time_out, done, false_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_seen = 0;
    test_reset();
    test_normal(40);
    for (int k = 0; k < 3; k++) test_normal(int'($urandom_range(12, 300)));
    test_saturation();
    test_false_start();
    test_abort(int'($urandom_range(10, 80)));
    test_spi(8'hA5);
    test_spi(8'h3C);
    for (int k = 0; k < 3; k++) test_spi(8'($urandom));
    test_normal(int'($urandom_range(20, 120)));
    test_reset_mid();
    test_spi(8'($urandom_range(1, 255)));
    test_normal(int'($urandom_range(20, 120)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
